tagged_mem_responder: RTL and testbench

Responder end of the processor's tagged memory bus: accepts LOAD/STORE commands from the processor (instruction or data port), hands back a non-zero transaction tag in the same cycle, and returns load data with that tag a fixed number of cycles later. Replaces the zero-latency behavioural memory in pipeline benches so that the processor's tag/response tracking, stall, and refusal paths are exercised. One instance per processor memory port.

---
 rtl/mem_bus_pkg.sv | 28 ++
 rtl/resp_delay_queue.sv | 101 ++++++++++
 rtl/tagged_mem_responder.sv | 78 +++++++
 tb/tb_tagged_mem_responder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types for the tagged processor/memory bus; tag 0 is reserved as "no tag"
// on both the same-cycle response and the delayed completion broadcast.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_e;

  typedef logic [3:0] mem_tag_t;

  localparam mem_tag_t MEM_TAG_NONE  = 4'd0;
  localparam mem_tag_t MEM_TAG_FIRST = 4'd1;

  // cnt is the number of cycles the entry still has to live in the queue
  typedef struct packed {
    mem_tag_t    tag;
    logic [31:0] data;
    logic [3:0]  cnt;
  } resp_entry_t;

  // Tag sequence 1..15, skipping the reserved 0
  function automatic mem_tag_t next_tag(input mem_tag_t t);
    return (t == 4'd15) ? MEM_TAG_FIRST : t + 4'd1;
  endfunction

endpackage

// File: rtl/resp_delay_queue.sv
// In-order completion queue: each pushed entry broadcasts LATENCY cycles after push and frees its
// slot one cycle after the broadcast; no backpressure, the caller must gate pushes on occupancy/retire.
module resp_delay_queue
  import mem_bus_pkg::*;
#(
  parameter int LATENCY         = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int OCC_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld_i,
  input  mem_tag_t         push_tag_i,
  input  logic [31:0]      push_dat_i,
  output logic             retire_o,
  output logic [OCC_W-1:0] occupancy_o,
  output mem_tag_t         bcast_tag_o,
  output logic [31:0]      bcast_dat_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  resp_entry_t                entry_q [MAX_OUTSTANDING];
  resp_entry_t                entry_d [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] vld_q, vld_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]           occ_q, occ_d;
  mem_tag_t                   bcast_tag_q, bcast_tag_d;
  logic [31:0]                bcast_dat_q, bcast_dat_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign retire_o    = vld_q[rd_ptr_q] && (entry_q[rd_ptr_q].cnt == 4'd0);
  assign occupancy_o = occ_q;
  assign bcast_tag_o = bcast_tag_q;
  assign bcast_dat_o = bcast_dat_q;

  always_comb begin
    entry_d     = entry_q;
    vld_d       = vld_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    bcast_tag_d = MEM_TAG_NONE;
    bcast_dat_d = '0;

    // Entry with two cycles left loads the output register, so it is seen
    // during its LATENCY-th cycle and still holds its slot through that cycle.
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (vld_q[i]) begin
        if (entry_q[i].cnt != 4'd0) entry_d[i].cnt = entry_q[i].cnt - 4'd1;
        if (entry_q[i].cnt == 4'd2) begin
          bcast_tag_d = entry_q[i].tag;
          bcast_dat_d = entry_q[i].data;
        end
      end
    end

    if (retire_o) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = ptr_inc(rd_ptr_q);
    end

    // Push after retire so a full queue can refill the slot it just freed
    if (push_vld_i) begin
      entry_d[wr_ptr_q] = '{tag: push_tag_i, data: push_dat_i, cnt: 4'(LATENCY)};
      vld_d[wr_ptr_q]   = 1'b1;
      wr_ptr_d          = ptr_inc(wr_ptr_q);
      if (LATENCY == 1) begin
        bcast_tag_d = push_tag_i;
        bcast_dat_d = push_dat_i;
      end
    end

    occ_d = occ_q + OCC_W'(push_vld_i) - OCC_W'(retire_o);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      bcast_tag_q <= MEM_TAG_NONE;
      bcast_dat_q <= '0;
    end else begin
      vld_q       <= vld_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      bcast_tag_q <= bcast_tag_d;
      bcast_dat_q <= bcast_dat_d;
    end
  end

  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

endmodule

// File: rtl/tagged_mem_responder.sv
// Tagged memory responder: same-cycle tag response, load data LATENCY cycles later; refuses when slots are full.
// Define MEM_RESP_STORE_ACK_EN to make STOREs take a slot and broadcast a zero-data completion.
module tagged_mem_responder
  import mem_bus_pkg::*;
#(
  parameter int MEM_WORDS       = 16384,
  parameter int LATENCY         = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] proc2mem_addr,
  input  logic [31:0] proc2mem_data,
  input  logic [1:0]  proc2mem_command,
  output logic [3:0]  mem2proc_response,
  output logic [31:0] mem2proc_data,
  output logic [3:0]  mem2proc_tag
);

  localparam int          OCC_W      = $clog2(MAX_OUTSTANDING + 1);
  localparam int          IDX_W      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

  logic [31:0] unified_memory [MEM_WORDS];

  logic             is_load, is_store, in_range, slot_free, accept;
  logic             retire, push_vld;
  logic [OCC_W-1:0] occupancy;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      rd_data, push_dat;
  mem_tag_t         tag_q, tag_d;

  assign is_load   = (proc2mem_command == BUS_LOAD);
  assign is_store  = (proc2mem_command == BUS_STORE);
  assign in_range  = ({1'b0, proc2mem_addr} < ADDR_LIMIT);
  assign slot_free = (occupancy < OCC_W'(MAX_OUTSTANDING)) || retire;
  assign accept    = !rst && (is_load || is_store) && in_range && slot_free;
  assign word_idx  = proc2mem_addr[IDX_W+1:2];
  assign rd_data   = unified_memory[word_idx];

  assign mem2proc_response = accept ? tag_q : MEM_TAG_NONE;
  assign tag_d             = accept ? next_tag(tag_q) : tag_q;

`ifdef MEM_RESP_STORE_ACK_EN
  assign push_vld = accept;
  assign push_dat = is_load ? rd_data : '0;
`else
  assign push_vld = accept && is_load;
  assign push_dat = rd_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) tag_q <= MEM_TAG_FIRST;
    else     tag_q <= tag_d;
  end

  // Storage is deliberately left out of reset so preloaded images survive it
  always_ff @(posedge clk) begin
    if (accept && is_store) unified_memory[word_idx] <= proc2mem_data;
  end

  resp_delay_queue #(
    .LATENCY         (LATENCY),
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .OCC_W           (OCC_W)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .push_vld_i  (push_vld),
    .push_tag_i  (tag_q),
    .push_dat_i  (push_dat),
    .retire_o    (retire),
    .occupancy_o (occupancy),
    .bcast_tag_o (mem2proc_tag),
    .bcast_dat_o (mem2proc_data)
  );

endmodule

// File: tb/tb_tagged_mem_responder.sv
// Randomised and directed checks of tagged_mem_responder against a cycle-window reference model.
module tb_tagged_mem_responder;
  import mem_bus_pkg::*;

  localparam int MEM_WORDS = 16384;
  localparam int LATENCY   = 4;
  localparam int MAX_OUT   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdat;
  logic [1:0]  cmd;
  logic [3:0]  resp, ctag;
  logic [31:0] cdat;

  always #5 clk = ~clk;

  tagged_mem_responder #(
    .MEM_WORDS       (MEM_WORDS),
    .LATENCY         (LATENCY),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .proc2mem_addr     (addr),
    .proc2mem_data     (wdat),
    .proc2mem_command  (cmd),
    .mem2proc_response (resp),
    .mem2proc_data     (cdat),
    .mem2proc_tag      (ctag)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Reference model: memory contents, expected completions by cycle,
  // acceptance cycles of slot-holding commands, and the next tag to hand out.
  logic [31:0] m_mem   [int];
  logic [35:0] m_sched [int];
  int          m_slots [$];
  logic [3:0]  m_tag;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  // A command accepted in cycle n holds a slot during cycles n+1 .. n+LATENCY
  function automatic int m_occ();
    int n = 0;
    foreach (m_slots[i]) if (m_slots[i] >= cyc - LATENCY) n++;
    return n;
  endfunction

  // Called at posedge+1; drives one cycle, checks it, advances to next posedge+1
  task automatic step(input logic r, input logic [1:0] c, input logic [31:0] a,
                      input logic [31:0] d, output logic [3:0] got);
    logic        is_ld, is_st, acc, takes;
    logic [3:0]  exp_resp;
    logic [35:0] ev;
    rst  = r;
    cmd  = c;
    addr = a;
    wdat = d;
    #4;
    is_ld    = (c == 2'd1);
    is_st    = (c == 2'd2);
    acc      = !r && (is_ld || is_st) && (64'(a) < 64'(MEM_WORDS) * 4) && (m_occ() < MAX_OUT);
    exp_resp = acc ? m_tag : 4'd0;
    got      = resp;
    chk("response", resp, exp_resp);
    ev = m_sched.exists(cyc) ? m_sched[cyc] : 36'd0;
    chk("cpl_tag", ctag, ev[35:32]);
    if (ev[35:32] != 4'd0) chk("cpl_data", cdat, ev[31:0]);
    if (r) begin
      m_slots.delete();
      for (int k = cyc + 1; k <= cyc + LATENCY + 1; k++) m_sched.delete(k);
      m_tag = 4'd1;
    end else if (acc) begin
`ifdef MEM_RESP_STORE_ACK_EN
      takes = is_ld || is_st;
`else
      takes = is_ld;
`endif
      if (is_st) m_mem[int'(a[31:2])] = d;
      if (takes) begin
        m_slots.push_back(cyc);
        m_sched[cyc + LATENCY] = {m_tag, is_ld ? m_mem[int'(a[31:2])] : 32'd0};
      end
      m_tag = (m_tag == 4'd15) ? 4'd1 : m_tag + 4'd1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    logic [3:0] dummy;
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 32'd0, 32'd0, dummy);
  endtask

  task automatic do_reset();
    logic [3:0] dummy;
    step(1'b1, 2'd0, 32'd0, 32'd0, dummy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic [3:0] r;
    logic [3:0] five [5];
    m_tag = 4'd1;
    rst   = 1'b1;
    cmd   = 2'd0;
    addr  = '0;
    wdat  = '0;
    repeat (2) @(posedge clk);
    #1;

    chk("rst_cpl_tag", ctag, 32'd0);
    chk("rst_cpl_data", cdat, 32'd0);
    step(1'b1, 2'd1, 32'h10, 32'd0, r);
    chk("resp_during_rst", r, 32'd0);

    // Preload word 4, then reset: the array must keep its contents
    step(1'b0, 2'd2, 32'h10, 32'hDEADBEEF, r);
    idle(2);
    do_reset();
    step(1'b0, 2'd1, 32'h10, 32'd0, r);
    chk("first_load_tag", r, 32'd1);
    idle(LATENCY + 2);

    // Store then load of the same word on the next cycle
    do_reset();
    step(1'b0, 2'd2, 32'h20, 32'h12345678, r);
    chk("store_tag", r, 32'd1);
    step(1'b0, 2'd1, 32'h20, 32'd0, r);
    chk("load_after_store_tag", r, 32'd2);
    idle(LATENCY + 2);

    // Five back-to-back loads against four slots, then a retry
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 2'd1, 32'h10, 32'd0, five[i]);
    for (int i = 0; i < 4; i++) chk("b2b_tag", five[i], 32'(i + 1));
    chk("b2b_refused", five[4], 32'd0);
    step(1'b0, 2'd1, 32'h10, 32'd0, r);
    chk("b2b_retry_tag", r, 32'd5);
    idle(LATENCY + 2);

    // Tag wrap: 15 is followed by 1
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 2'd1, 32'h20, 32'd0, r);
      chk("wrap_tag", r, 32'((i % 15) + 1));
      idle(LATENCY);
    end

    // Out-of-range load is refused and consumes no tag
    do_reset();
    step(1'b0, 2'd1, 32'(MEM_WORDS * 4), 32'd0, r);
    chk("oob_refused", r, 32'd0);
    step(1'b0, 2'd1, 32'(MEM_WORDS * 4 - 4), 32'd0, r);
    chk("last_word_tag", r, 32'd1);
    idle(LATENCY + 2);

    // Reset with three loads in flight: nothing broadcasts afterwards
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 2'd1, 32'h10, 32'd0, r);
    do_reset();
    idle(LATENCY + 2);
    step(1'b0, 2'd1, 32'h10, 32'd0, r);
    chk("after_drop_tag", r, 32'd1);
    idle(LATENCY + 2);

    // Random traffic over a pre-written window of 16 words
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 2'd2, 32'h100 + 32'(4 * i), $urandom, r);
      idle(1);
    end
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0) a = 32'(MEM_WORDS * 4) + 32'(4 * $urandom_range(0, 15));
      else a = 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      step(($urandom_range(0, 99) == 0), 2'($urandom_range(0, 3)), a, $urandom, r);
    end
    idle(LATENCY + 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
